// File: rtl/obstacle_pkg.sv
// obstacle_pkg: shared types, LFSR taps and gap helper for the obstacle field
package obstacle_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    OVER
  } obst_state_t;

  typedef struct packed {
    logic signed [11:0] xpos;
    logic [11:0]        gap_y;
  } obstacle_t;

  // Galois mask for x^16 + x^14 + x^13 + x^11 (right-shifting form)
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  // Map the low 10 LFSR bits onto [gap_min, gap_min + range); range >= 256 keeps
  // four subtractions sufficient for any 10-bit value.
  function automatic logic [11:0] gap_from_lfsr(input logic [15:0] lfsr,
                                                input logic [11:0] gap_min,
                                                input logic [11:0] range);
    logic [11:0] v;
    v = {2'b00, lfsr[9:0]};
    for (int k = 0; k < 4; k++) v = (v >= range) ? v - range : v;
    return gap_min + v;
  endfunction

endpackage

// File: rtl/obst_lfsr.sv
// obst_lfsr: free-running 16-bit Galois LFSR, reloads its seed on reset
module obst_lfsr
  import obstacle_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  output logic [15:0] o_lfsr
);

  logic [15:0] r_lfsr;

  // Shift right every clock, folding the taps in when a one falls out
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) r_lfsr <= SEED;
    else          r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? LFSR_TAPS : 16'h0000);

  assign o_lfsr = r_lfsr;

endmodule

// File: rtl/obstacle_field_ctl.sv
// obstacle_field_ctl: scrolling ring of obstacle columns with score and collision FSM
module obstacle_field_ctl
  import obstacle_pkg::*;
#(
  parameter int          NUM_OBST  = 3,
  parameter int          SCREEN_W  = 800,
  parameter int          SCREEN_H  = 600,
  parameter int          OBST_W    = 60,
  parameter int          GAP_H     = 180,
  parameter int          GAP_MIN   = 50,
  parameter int          SPACING   = 300,
  parameter int          SPEED     = 2,
  parameter int          PLAYER_X  = 100,
  parameter int          PLAYER_W  = 40,
  parameter int          PLAYER_H  = 40,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_frame_tick,
  input  logic                    i_start,
  input  logic [11:0]             i_player_ypos,
  output logic [NUM_OBST*12-1:0]  o_obst_xpos,
  output logic [NUM_OBST*12-1:0]  o_obst_gap_y,
  output logic [15:0]             o_score,
  output logic                    o_running,
  output logic                    o_endgame
);

  localparam int RANGE = SCREEN_H - GAP_H - 2 * GAP_MIN;
  localparam int RSTEP = RANGE / NUM_OBST;

  // All geometry is compared in 14-bit signed so negative left edges behave
  localparam logic signed [13:0] C_W   = 14'(OBST_W);
  localparam logic signed [13:0] C_SPD = 14'(SPEED);
  localparam logic signed [13:0] C_SPC = 14'(SPACING);
  localparam logic signed [13:0] C_PX  = 14'(PLAYER_X);
  localparam logic signed [13:0] C_PW  = 14'(PLAYER_W);
  localparam logic signed [13:0] C_PH  = 14'(PLAYER_H);
  localparam logic signed [13:0] C_GH  = 14'(GAP_H);
  localparam logic signed [13:0] C_SH  = 14'(SCREEN_H);

  generate
    if (RANGE < 256) begin : g_chk_range
      $error("obstacle_field_ctl: SCREEN_H - GAP_H - 2*GAP_MIN must be >= 256");
    end
    if (SPACING <= OBST_W) begin : g_chk_spacing
      $error("obstacle_field_ctl: SPACING must exceed OBST_W");
    end
    if (NUM_OBST < 2 || NUM_OBST > 8) begin : g_chk_num
      $error("obstacle_field_ctl: NUM_OBST must be 2..8");
    end
  endgenerate

  function automatic obstacle_t init_obst(input int i);
    return '{xpos: 12'(SCREEN_W + i * SPACING), gap_y: 12'(GAP_MIN + i * RSTEP)};
  endfunction

  obst_state_t          r_state, w_state_nxt;
  logic                 r_running, r_endgame;
  logic [15:0]          r_score, w_score_nxt;
  logic [16:0]          w_score_sum;
  logic [15:0]          w_lfsr;
  logic [11:0]          w_gap;
  logic                 w_init, w_tick, w_coll;
  logic signed [13:0]   w_py;
  logic [NUM_OBST-1:0]  w_respawn, w_cross, w_hit;

  obst_lfsr #(.SEED(LFSR_SEED)) u_lfsr (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .o_lfsr  (w_lfsr)
  );

  assign w_gap  = gap_from_lfsr(w_lfsr, 12'(GAP_MIN), 12'(RANGE));
  assign w_py   = {2'b00, i_player_ypos};
  assign w_tick = i_frame_tick && (r_state == RUN);

  for (genvar i = 0; i < NUM_OBST; i++) begin : g_col
    localparam int P = (i + NUM_OBST - 1) % NUM_OBST;
    obstacle_t          r_obst, w_nxt;
    logic signed [13:0] w_x, w_xp, w_xm, w_g;
    assign w_x  = {{2{r_obst.xpos[11]}}, r_obst.xpos};
    assign w_xp = {{2{o_obst_xpos[P*12+11]}}, o_obst_xpos[P*12 +: 12]};
    assign w_xm = w_x - C_SPD;
    assign w_g  = {2'b00, r_obst.gap_y};
    assign w_respawn[i] = (w_x + C_W) <= C_SPD;
    // Right edge steps from at-or-right of the player's left edge to left of it
    assign w_cross[i] = !w_respawn[i] && (w_x + C_W >= C_PX) && (w_xm + C_W < C_PX);
    assign w_hit[i] = (w_x < C_PX + C_PW) && (w_x + C_W > C_PX) &&
                      ((w_py < w_g) || (w_py + C_PH > w_g + C_GH));
    // Respawned columns line up behind their predecessor, which itself moves this tick
    assign w_nxt = '{xpos:  w_respawn[i] ? 12'(w_xp + C_SPC - C_SPD) : w_xm[11:0],
                     gap_y: w_respawn[i] ? w_gap : r_obst.gap_y};
    // Column position register: initial layout on reset/restart, scroll on tick in RUN
    always_ff @(posedge i_clk or negedge i_rst_n)
      if (!i_rst_n)    r_obst <= init_obst(i);
      else if (w_init) r_obst <= init_obst(i);
      else if (w_tick) r_obst <= w_nxt;
    assign o_obst_xpos[i*12 +: 12]  = r_obst.xpos;
    assign o_obst_gap_y[i*12 +: 12] = r_obst.gap_y;
  end

  assign w_coll      = (|w_hit) || (w_py + C_PH > C_SH);
  assign w_score_sum = {1'b0, r_score} + 17'($countones(w_cross));
  assign w_score_nxt = w_score_sum[16] ? 16'hFFFF : w_score_sum[15:0];

  // Next-state logic; a start outside RUN also re-initialises the layout
  always_comb begin
    w_state_nxt = r_state;
    w_init      = 1'b0;
    case (r_state)
      RUN:        w_state_nxt = w_coll ? OVER : RUN;
      IDLE, OVER: begin
        w_init      = i_start;
        w_state_nxt = i_start ? RUN : r_state;
      end
      default:    w_state_nxt = IDLE;
    endcase
  end

  // State register with status outputs registered alongside it
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n) begin
      r_state   <= IDLE;
      r_running <= 1'b0;
      r_endgame <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_running <= (w_state_nxt == RUN);
      r_endgame <= (w_state_nxt == OVER);
    end

  // Score: cleared on restart, accumulates column crossings on each tick in RUN
  always_ff @(posedge i_clk or negedge i_rst_n)
    if (!i_rst_n)    r_score <= 16'h0000;
    else if (w_init) r_score <= 16'h0000;
    else if (w_tick) r_score <= w_score_nxt;

  assign o_score   = r_score;
  assign o_running = r_running;
  assign o_endgame = r_endgame;

endmodule
